// File: rtl/reset_sequencer.sv
// SoC reset generator: synchronises PLL lock and GRESET, debounces the button, holds reset
// for HOLD_CYCLES after lock with the button released, and records the cause of the last reset.
module reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 256
) (
    input  logic       io_mainClk,
    input  logic       io_asyncResetn,
    input  logic       io_pllLocked,
    input  logic       io_greset,
    output logic       io_systemReset,
    output logic [1:0] io_resetCause,
    output logic       io_buttonPressed,
    output logic [7:0] io_resetCount
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] CAUSE_PLL = 2'b01;
    localparam logic [1:0] CAUSE_BTN = 2'b10;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic                   lock_s;
    logic                   btn_s;

    logic [DB_W-1:0]        db_cnt_q;
    logic [DB_W-1:0]        db_cnt_d;
    logic                   pressed_q;
    logic                   pressed_d;
    logic                   pressed_d1_q;
    logic                   btn_rise;

    state_t                 state_q;
    state_t                 state_d;
    logic [HOLD_W-1:0]      hold_cnt_q;
    logic [HOLD_W-1:0]      hold_cnt_d;
    logic [1:0]             cause_q;
    logic [1:0]             cause_d;
    logic [7:0]             count_q;
    logic [7:0]             count_d;
    logic                   sys_rst_q;
    logic                   sys_rst_d;

    assign lock_s   = lock_sync_q[SYNC_STAGES-1];
    assign btn_s    = btn_sync_q[SYNC_STAGES-1];
    assign btn_rise = pressed_q & ~pressed_d1_q;

    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            lock_sync_q  <= '0;
            btn_sync_q   <= '0;
            db_cnt_q     <= '0;
            pressed_q    <= 1'b0;
            pressed_d1_q <= 1'b0;
        end else begin
            lock_sync_q  <= {lock_sync_q[SYNC_STAGES-2:0], io_pllLocked};
            btn_sync_q   <= {btn_sync_q[SYNC_STAGES-2:0], io_greset};
            db_cnt_q     <= db_cnt_d;
            pressed_q    <= pressed_d;
            pressed_d1_q <= pressed_q;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        db_cnt_d  = db_cnt_q;
        pressed_d = pressed_q;
        if (btn_s == pressed_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            pressed_d = ~pressed_q;
            db_cnt_d  = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            state_q    <= ST_WAIT_LOCK;
            hold_cnt_q <= '0;
            cause_q    <= 2'b00;
            count_q    <= 8'd0;
            sys_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            cause_q    <= cause_d;
            count_q    <= count_d;
            sys_rst_q  <= sys_rst_d;
        end
    end

    // Lock loss is tested first everywhere so it wins over a coincident button edge.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cause_d    = cause_q;
        count_d    = count_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cause_d = CAUSE_PLL;
                end else if (pressed_q) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cause_d = CAUSE_PLL;
                end else if (btn_rise) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                    cause_d    = CAUSE_BTN;
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase
    end

    always_comb begin
        sys_rst_d = (state_d != ST_RUN);
    end

    assign io_systemReset   = sys_rst_q;
    assign io_resetCause    = cause_q;
    assign io_buttonPressed = pressed_q;
    assign io_resetCount    = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised bench for reset_sequencer against a cycle-level behavioural model
// (countdown hold timer, run-length debouncer, delay-line synchronisers).
module tb_reset_sequencer;

    localparam int S = 2;
    localparam int D = 4;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll = 1'b0;
    logic       btn = 1'b0;
    logic       sys_rst;
    logic [1:0] cause;
    logic       pressed;
    logic [7:0] count;

    int total = 0;
    int bad = 0;

    reset_sequencer #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H)
    ) dut (
        .io_mainClk      (clk),
        .io_asyncResetn  (rst_n),
        .io_pllLocked    (pll),
        .io_greset       (btn),
        .io_systemReset  (sys_rst),
        .io_resetCause   (cause),
        .io_buttonPressed(pressed),
        .io_resetCount   (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    // Behavioural model state
    bit m_lk[S];
    bit m_bt[S];
    bit m_pr, m_pr1, m_rst, m_wait;
    int m_left, m_run, m_cause, m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < S; i++) begin
            m_lk[i] = 1'b0;
            m_bt[i] = 1'b0;
        end
        m_pr = 0; m_pr1 = 0; m_rst = 1; m_wait = 1;
        m_left = 0; m_run = 0; m_cause = 0; m_cnt = 0;
    endfunction

    function automatic void model_step(input bit lin, input bit bin);
        bit lk, bs, pr, pr1;
        lk = m_lk[S-1]; bs = m_bt[S-1]; pr = m_pr; pr1 = m_pr1;
        if (!m_rst) begin
            if (!lk) begin
                m_rst = 1; m_wait = 1; m_cause = 1;
            end else if (pr && !pr1) begin
                m_rst = 1; m_wait = 0; m_left = H; m_cause = 2;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
        end else if (m_wait) begin
            if (lk) begin
                m_wait = 0; m_left = H;
            end
        end else begin
            if (!lk) begin
                m_wait = 1; m_cause = 1;
            end else if (pr) begin
                m_left = H;
            end else begin
                m_left--;
                if (m_left == 0) m_rst = 0;
            end
        end
        if (bs != pr) begin
            m_run++;
            if (m_run == D) begin
                m_pr = !pr; m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_pr1 = pr;
        for (int i = S - 1; i > 0; i--) begin
            m_lk[i] = m_lk[i-1];
            m_bt[i] = m_bt[i-1];
        end
        m_lk[0] = lin;
        m_bt[0] = bin;
    endfunction

    task automatic compare_all();
        check("sysrst", sys_rst, m_rst);
        check("cause", cause, m_cause);
        check("pressed", pressed, m_pr);
        check("count", count, m_cnt);
    endtask

    task automatic cyc(input bit l, input bit b);
        pll = l;
        btn = b;
        @(posedge clk);
        model_step(l, b);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
    endtask

    initial begin
        int first_low;
        int k;
        int cnt_before;
        int kind;
        int len;

        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("por_sysrst", sys_rst, 1);
        check("por_cause", cause, 0);
        check("por_pressed", pressed, 0);
        check("por_count", count, 0);
        rst_n = 1'b1;

        // Power-on: release edge counted from the first edge sampling lock high.
        first_low = -1;
        for (int c = 0; c < 20; c++) begin
            cyc(1'b1, 1'b0);
            if (sys_rst == 1'b0 && first_low < 0) first_low = c + 1;
        end
        check("poweron_release_edge", first_low, S + H + 1);

        // Bounce then steady press.
        cyc(1'b1, 1'b1); check("bounce_norst", sys_rst, 0);
        cyc(1'b1, 1'b0); check("bounce_norst", sys_rst, 0);
        cyc(1'b1, 1'b1); check("bounce_norst", sys_rst, 0);
        cyc(1'b1, 1'b0); check("bounce_norst", sys_rst, 0);
        k = 0;
        while (pressed !== 1'b1 && k < 20) begin
            cyc(1'b1, 1'b1);
            k++;
        end
        check("bounce_latency", k, S + D);
        for (int i = 0; i < 14; i++) cyc(1'b1, 1'b1);
        idle(S + D + H + 4);
        check("btn_cause", cause, 2);
        check("btn_count", count, 1);
        check("btn_released", sys_rst, 0);

        // PLL drop from RUN.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
        check("pll_cause", cause, 1);
        idle(S + H + 4);
        check("pll_released", sys_rst, 0);

        // Randomised phases.
        for (int p = 0; p < 40; p++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    len = $urandom_range(5, 30);
                    for (int i = 0; i < len; i++) cyc(1'b1, 1'($urandom_range(0, 1)));
                end
                1: begin
                    len = $urandom_range(1, 25);
                    for (int i = 0; i < len; i++) cyc(1'b1, 1'b1);
                end
                2: begin
                    len = $urandom_range(1, 6);
                    for (int i = 0; i < len; i++) cyc(1'b0, 1'($urandom_range(0, 1)));
                end
                default: begin
                    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1);
                    idle(3);
                    len = $urandom_range(1, 4);
                    for (int i = 0; i < len; i++) cyc(1'b0, 1'b0);
                end
            endcase
            idle(S + D + H + 4);
        end

        // Lock fall lands on the same cycle as btnRise.
        idle(S + D + H + 4);
        cnt_before = m_cnt;
        for (int i = 0; i < D; i++) cyc(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
        check("simul_cause", cause, 1);
        check("simul_count", count, cnt_before);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
        idle(S + D + H + 4);

        // Saturation of the button counter.
        for (int n = 0; n < 260; n++) begin
            for (int i = 0; i < S + D + 2; i++) cyc(1'b1, 1'b1);
            idle(S + D + H + 3);
        end
        check("sat_count", count, 255);

        // Async reset while in HOLD with the button held.
        for (int i = 0; i < S + D + 3; i++) cyc(1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_sysrst", sys_rst, 1);
        check("arst_cause", cause, 0);
        check("arst_pressed", pressed, 0);
        check("arst_count", count, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(S + H + 6);
        check("arst_recovered", sys_rst, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
